// File: rtl/fighter_pkg.sv
// Shared constants and state encodings for the fighter kinematics slice.
package fighter_pkg;

  typedef enum logic [1:0] {
    ST_GROUND = 2'b00,
    ST_AIR    = 2'b01,
    ST_LAND   = 2'b10
  } state_t;

  localparam int X_MIN       = 15;
  localparam int X_MAX       = 75;
  localparam int FLOOR_Y     = 48;
  localparam int CEIL_Y      = 15;
  localparam int KNOCK_TICKS = 3;

endpackage

// File: rtl/fighter_vert_fsm.sv
// Vertical motion FSM: jump launch, gravity with fall cap, ceiling bump and landing lag.
module fighter_vert_fsm #(
  parameter int Y_W        = 7,
  parameter int FLOOR_Y    = fighter_pkg::FLOOR_Y,
  parameter int CEIL_Y     = fighter_pkg::CEIL_Y,
  parameter int JUMP_VEL   = 7,
  parameter int GRAVITY    = 1,
  parameter int VMAX_FALL  = 7,
  parameter int LAND_TICKS = 2
) (
  input  logic                  CLK_20Hz,
  input  logic                  reset,
  input  logic                  jump_req,
  output logic [Y_W-1:0]        pos_y,
  output logic signed [Y_W:0]   vel_y,
  output logic                  airborne,
  output logic [1:0]            state
);
  import fighter_pkg::*;

  localparam int YC = Y_W + 2;
  localparam logic signed [YC-1:0] FLOOR_S = YC'(FLOOR_Y);
  localparam logic signed [YC-1:0] CEIL_S  = YC'(CEIL_Y);
  localparam logic signed [YC-1:0] JUMP_S  = YC'(JUMP_VEL);
  localparam logic signed [YC-1:0] GRAV_S  = YC'(GRAVITY);
  localparam logic signed [YC-1:0] VMAX_S  = YC'(VMAX_FALL);

  state_t                 st, st_n;
  logic [3:0]             cnt, cnt_n;
  logic [Y_W-1:0]         py_n;
  logic signed [Y_W:0]    vy_n;
  logic signed [YC-1:0]   y_cur, v_cur, v_sum, v_lim, y_sum, y_jump;

  always_ff @(posedge CLK_20Hz) begin
    if (reset) begin
      st       <= ST_GROUND;
      pos_y    <= Y_W'(FLOOR_Y);
      vel_y    <= '0;
      cnt      <= '0;
      airborne <= 1'b0;
    end else begin
      st       <= st_n;
      pos_y    <= py_n;
      vel_y    <= vy_n;
      cnt      <= cnt_n;
      airborne <= (st_n == ST_AIR);
    end
  end

  assign state = st;

  always_comb begin
    st_n   = st;
    py_n   = pos_y;
    vy_n   = vel_y;
    cnt_n  = cnt;
    y_cur  = $signed({2'b00, pos_y});
    v_cur  = {vel_y[Y_W], vel_y};
    v_sum  = v_cur + GRAV_S;
    v_lim  = (v_sum > VMAX_S) ? VMAX_S : v_sum;
    y_sum  = y_cur + v_lim;
    y_jump = y_cur - JUMP_S;
    case (st)
      ST_GROUND: begin
        if (jump_req) begin
          st_n = ST_AIR;
          vy_n = (Y_W+1)'(-JUMP_S);
          py_n = Y_W'(y_jump);
        end
      end
      ST_AIR: begin
        // floor test takes priority so a fast fall never reports a head bump
        if (y_sum >= FLOOR_S) begin
          st_n  = ST_LAND;
          py_n  = Y_W'(FLOOR_Y);
          vy_n  = '0;
          cnt_n = 4'(LAND_TICKS - 1);
        end else if (y_sum <= CEIL_S) begin
          py_n = Y_W'(CEIL_Y);
          vy_n = '0;
        end else begin
          py_n = Y_W'(y_sum);
          vy_n = (Y_W+1)'(v_lim);
        end
      end
      ST_LAND: begin
        if (cnt == '0) st_n = ST_GROUND;
        else           cnt_n = cnt - 4'd1;
      end
      default: st_n = ST_GROUND;
    endcase
  end

endmodule

// File: rtl/fighter_kinematics.sv
// Per-fighter position integrator: saturating walk with collision blocking plus vertical FSM.
// Optional knockback enabled by defining FIGHTER_KNOCKBACK_EN.
module fighter_kinematics #(
  parameter int X_W        = 7,
  parameter int Y_W        = 7,
  parameter int SPAWN_X    = 15,
  parameter int X_MIN      = fighter_pkg::X_MIN,
  parameter int X_MAX      = fighter_pkg::X_MAX,
  parameter int FLOOR_Y    = fighter_pkg::FLOOR_Y,
  parameter int CEIL_Y     = fighter_pkg::CEIL_Y,
  parameter int WALK_STEP  = 2,
  parameter int JUMP_VEL   = 7,
  parameter int GRAVITY    = 1,
  parameter int VMAX_FALL  = 7,
  parameter int LAND_TICKS = 2
) (
  input  logic                CLK_20Hz,
  input  logic                reset,
  input  logic                move_left,
  input  logic                move_right,
  input  logic                jump_req,
  input  logic                blocked_left,
  input  logic                blocked_right,
  input  logic                knock_req,
  input  logic                knock_dir,
  output logic [X_W-1:0]      pos_x,
  output logic [Y_W-1:0]      pos_y,
  output logic signed [Y_W:0] vel_y,
  output logic                airborne,
  output logic [1:0]          state
);
  import fighter_pkg::*;

  localparam int XC = X_W + 2;
  localparam logic signed [XC-1:0] XMIN_S = XC'(X_MIN);
  localparam logic signed [XC-1:0] XMAX_S = XC'(X_MAX);
  localparam logic signed [XC-1:0] WALK_S = XC'(WALK_STEP);

  logic signed [XC-1:0] walk_step, step, x_sum, x_sat;

`ifdef FIGHTER_KNOCKBACK_EN
  localparam logic signed [XC-1:0] KNOCK_S = XC'(3 * WALK_STEP);
  logic [1:0] knock_cnt;
  logic       knock_dir_r;

  always_ff @(posedge CLK_20Hz) begin
    if (reset) begin
      knock_cnt   <= '0;
      knock_dir_r <= 1'b0;
    end else if (knock_req) begin
      knock_cnt   <= 2'(KNOCK_TICKS);
      knock_dir_r <= knock_dir;
    end else if (knock_cnt != '0) begin
      knock_cnt   <= knock_cnt - 2'd1;
    end
  end
`else
  logic unused_knock;
  assign unused_knock = knock_req ^ knock_dir;
`endif

  always_comb begin
    walk_step = '0;
    if (move_left && !move_right)      walk_step = -WALK_S;
    else if (move_right && !move_left) walk_step = WALK_S;
    step = walk_step;
`ifdef FIGHTER_KNOCKBACK_EN
    if (knock_cnt != '0) step = knock_dir_r ? KNOCK_S : -KNOCK_S;
`endif
    if (step[XC-1] && blocked_left)               step = '0;
    if (!step[XC-1] && step != '0 && blocked_right) step = '0;
    x_sum = $signed({2'b00, pos_x}) + step;
    x_sat = x_sum;
    if (x_sum < XMIN_S)      x_sat = XMIN_S;
    else if (x_sum > XMAX_S) x_sat = XMAX_S;
  end

  always_ff @(posedge CLK_20Hz) begin
    if (reset) pos_x <= X_W'(SPAWN_X);
    else       pos_x <= X_W'(x_sat);
  end

  fighter_vert_fsm #(
    .Y_W       (Y_W),
    .FLOOR_Y   (FLOOR_Y),
    .CEIL_Y    (CEIL_Y),
    .JUMP_VEL  (JUMP_VEL),
    .GRAVITY   (GRAVITY),
    .VMAX_FALL (VMAX_FALL),
    .LAND_TICKS(LAND_TICKS)
  ) u_vert (
    .CLK_20Hz (CLK_20Hz),
    .reset    (reset),
    .jump_req (jump_req),
    .pos_y    (pos_y),
    .vel_y    (vel_y),
    .airborne (airborne),
    .state    (state)
  );

endmodule

// File: tb/tb_fighter_kinematics.sv
// Directed self-checking bench for fighter_kinematics (P1 spawn 15, second instance spawn 74).
module tb_fighter_kinematics;

  logic       CLK_20Hz = 1'b0;
  logic       reset = 1'b1;
  logic       move_left = 1'b0, move_right = 1'b0, jump_req = 1'b0;
  logic       blocked_left = 1'b0, blocked_right = 1'b0;
  logic       knock_req = 1'b0, knock_dir = 1'b0;
  logic [6:0] pos_x, pos_y, p2_pos_x, p2_pos_y;
  logic signed [7:0] vel_y, p2_vel_y;
  logic       airborne, p2_airborne;
  logic [1:0] state, p2_state;

  int checks = 0;
  int failures = 0;
  int exp_y [14] = '{35, 30, 26, 23, 21, 20, 20, 21, 23, 26, 30, 35, 41, 48};

  always #5 CLK_20Hz = ~CLK_20Hz;

  fighter_kinematics #(.SPAWN_X(15)) dut (
    .CLK_20Hz(CLK_20Hz), .reset(reset), .move_left(move_left), .move_right(move_right),
    .jump_req(jump_req), .blocked_left(blocked_left), .blocked_right(blocked_right),
    .knock_req(knock_req), .knock_dir(knock_dir), .pos_x(pos_x), .pos_y(pos_y),
    .vel_y(vel_y), .airborne(airborne), .state(state)
  );

  fighter_kinematics #(.SPAWN_X(74)) dut2 (
    .CLK_20Hz(CLK_20Hz), .reset(reset), .move_left(move_left), .move_right(move_right),
    .jump_req(jump_req), .blocked_left(blocked_left), .blocked_right(blocked_right),
    .knock_req(knock_req), .knock_dir(knock_dir), .pos_x(p2_pos_x), .pos_y(p2_pos_y),
    .vel_y(p2_vel_y), .airborne(p2_airborne), .state(p2_state)
  );

  task automatic tick();
    @(posedge CLK_20Hz);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    tick(); tick();
    chk("rst_pos_x", pos_x, 15);
    chk("rst_pos_y", pos_y, 48);
    chk("rst_vel_y", vel_y, 0);
    chk("rst_state", state, 0);
    chk("rst_airborne", airborne, 0);
    chk("rst_p2_pos_x", p2_pos_x, 74);
    reset = 1'b0;

    move_left = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("left_sat_x", pos_x, 15);
    end
    move_left = 1'b0;

    reset = 1'b1; tick(); reset = 1'b0;
    chk("p2_respawn", p2_pos_x, 74);
    move_right = 1'b1;
    tick();
    chk("p2_right_sat", p2_pos_x, 75);
    chk("walk_right", pos_x, 17);
    tick();
    chk("p2_right_hold", p2_pos_x, 75);
    chk("walk_right2", pos_x, 19);
    move_left = 1'b1;
    tick();
    chk("both_dirs", pos_x, 19);
    chk("p2_both_dirs", p2_pos_x, 75);
    move_left = 1'b0;

    blocked_right = 1'b1;
    tick();
    chk("blk_r_right", pos_x, 19);
    move_right = 1'b0; move_left = 1'b1;
    tick();
    chk("blk_r_left", pos_x, 17);
    blocked_right = 1'b0; blocked_left = 1'b1;
    tick();
    chk("blk_l_left", pos_x, 17);
    move_left = 1'b0; blocked_left = 1'b0;

    jump_req = 1'b1;
    tick();
    jump_req = 1'b0;
    chk("jump_y", pos_y, 41);
    chk("jump_vel", vel_y, -7);
    chk("jump_state", state, 1);
    chk("jump_airborne", airborne, 1);
    for (int i = 0; i < 14; i++) begin
      tick();
      chk("arc_y", pos_y, exp_y[i]);
      chk("arc_vel", vel_y, (i < 13) ? i - 6 : 0);
      chk("arc_state", state, (i < 13) ? 1 : 2);
    end
    chk("land_airborne", airborne, 0);
    tick();
    chk("land_lag1", state, 2);
    tick();
    chk("land_to_ground", state, 0);

    jump_req = 1'b1;
    tick();
    chk("hold_jump_state", state, 1);
    repeat (14) tick();
    chk("hold_land_state", state, 2);
    chk("hold_land_y", pos_y, 48);
    tick();
    chk("hold_no_rejump", state, 2);
    chk("hold_no_rejump_y", pos_y, 48);
    tick();
    chk("hold_ground", state, 0);
    tick();
    chk("hold_rejump", state, 1);
    chk("hold_rejump_y", pos_y, 41);
    jump_req = 1'b0;
    tick();
    chk("air_y", pos_y, 35);
    reset = 1'b1; move_right = 1'b1;
    tick();
    chk("midair_rst_x", pos_x, 15);
    chk("midair_rst_y", pos_y, 48);
    chk("midair_rst_vel", vel_y, 0);
    chk("midair_rst_state", state, 0);
    chk("midair_rst_air", airborne, 0);
    reset = 1'b0;

`ifdef FIGHTER_KNOCKBACK_EN
    repeat (12) tick();
    chk("kb_start_x", pos_x, 39);
    knock_req = 1'b1; knock_dir = 1'b0;
    tick();
    knock_req = 1'b0;
    chk("kb_load_x", pos_x, 41);
    tick();
    chk("kb_x1", pos_x, 35);
    tick();
    chk("kb_x2", pos_x, 29);
    tick();
    chk("kb_x3", pos_x, 23);
    tick();
    chk("kb_walk_resume", pos_x, 25);
`endif
    move_right = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
